// File: rtl/bcd_addsub_n_if.sv
// Operand/result bundle for the digit-serial BCD adder/subtractor.
// The master drives the request and operands; the slave returns status and result.
interface bcd_addsub_n_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  neg;
  logic                  invalid;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, neg, invalid
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, neg, invalid
  );
endinterface

// File: rtl/bcd_addsub_n.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Negative differences are turned into sign-magnitude by a second nines-complement pass.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; results of the last operation held
//   ADD    | adding (or nines-complement subtracting) digit idx
//   FIX    | complementing a negative result back to magnitude, digit idx
//   DONE   | one-cycle completion pulse; start here chains a new op
module bcd_addsub_n #(
  parameter int DIGITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  bcd_addsub_n_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          sub_q;
  logic          carry;
  logic          cout_q;
  logic          neg_q;
  logic          inv_q;
  logic [IW-1:0] idx;

  logic          bad_digit;
  logic [3:0]    a_d;
  logic [3:0]    b_d;
  logic [3:0]    s_d;
  logic [3:0]    opx;
  logic [3:0]    opy;
  logic [4:0]    t;
  logic [3:0]    dig;
  logic          c_nxt;

  // Operand scan happens on the live inputs so a bad digit is caught at accept time.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      if (bus.b[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Shared single-digit decimal adder used by both passes.
  always_comb begin
    a_d = a_q[{idx, 2'b00} +: 4];
    b_d = b_q[{idx, 2'b00} +: 4];
    s_d = sum_q[{idx, 2'b00} +: 4];
    if (state == S_FIX) begin
      opx = 4'd9 - s_d;
      opy = 4'd0;
    end else begin
      opx = a_d;
      opy = sub_q ? (4'd9 - b_d) : b_d;
    end
    t = {1'b0, opx} + {1'b0, opy} + {4'b0000, carry};
    if (t > 5'd9) begin
      dig   = 4'(t - 5'd10);
      c_nxt = 1'b1;
    end else begin
      dig   = t[3:0];
      c_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      sub_q  <= 1'b0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      neg_q  <= 1'b0;
      inv_q  <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            sub_q  <= bus.sub;
            sum_q  <= '0;
            cout_q <= 1'b0;
            neg_q  <= 1'b0;
            idx    <= '0;
            carry  <= bus.sub;
            inv_q  <= bad_digit;
            state  <= bad_digit ? S_DONE : S_ADD;
          end else if (state == S_DONE) begin
            state <= S_IDLE;
          end
        end
        S_ADD: begin
          sum_q[{idx, 2'b00} +: 4] <= dig;
          if (idx == LAST) begin
            if (!sub_q) begin
              cout_q <= c_nxt;
              state  <= S_DONE;
            end else if (c_nxt) begin
              state <= S_DONE;
            end else begin
              neg_q <= 1'b1;
              idx   <= '0;
              carry <= 1'b1;
              state <= S_FIX;
            end
          end else begin
            idx   <= idx + 1'b1;
            carry <= c_nxt;
          end
        end
        S_FIX: begin
          sum_q[{idx, 2'b00} +: 4] <= dig;
          if (idx == LAST) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            carry <= c_nxt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == S_ADD) || (state == S_FIX);
  assign bus.done    = (state == S_DONE);
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.neg     = neg_q;
  assign bus.invalid = inv_q;

endmodule
